rc5_encipher: RTL and testbench

RC5 encryption engine. It is the forward-direction counterpart of the team's RC5 decipher block and shares the same expanded-key table (S) interface. The block takes one plaintext word pair (A,B) and runs pre-whitening followed by R rounds. Each round computes A=((A^B)<<<B)+S[2i] and then B=((B^A)<<<A)+S[2i+1]. Expanded-key words are fetched from an external synchronous S memory through two read-address ports, and the ciphertext pair is presented with a done flag.

---
 rtl/rc5_pkg.sv | 43 ++++
 rtl/rc5_rotl.sv | 25 ++
 rtl/rc5_encipher.sv | 133 +++++++++++++
 tb/tb_rc5_encipher.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: engine state encoding, size derivations and the
// word-size dependent magic constants used by key expansion.
package rc5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_READ = 3'd1,
        ST_PRE_ADD  = 3'd2,
        ST_RD       = 3'd3,
        ST_MIX_A    = 3'd4,
        ST_MIX_B    = 3'd5,
        ST_DONE     = 3'd6
    } rc5_state_e;

    function automatic int f_rot_value(input int w);
        return $clog2(w);
    endfunction

    function automatic int f_t(input int r);
        return 2 * (r + 1);
    endfunction

    function automatic int f_t_length(input int r);
        return $clog2(f_t(r));
    endfunction

    function automatic logic [63:0] f_magic_p(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_B7E1;
            64:      return 64'hB7E1_5162_8AED_2A6B;
            default: return 64'h0000_0000_B7E1_5163;
        endcase
    endfunction

    function automatic logic [63:0] f_magic_q(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_9E37;
            64:      return 64'h9E37_79B9_7F4A_7C15;
            default: return 64'h0000_0000_9E37_79B9;
        endcase
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational W-bit rotate-left built as log2(W) binary-weighted mux stages.
module rc5_rotl
    import rc5_pkg::*;
#(
    parameter int W = 32,
    localparam int ROT_VALUE = f_rot_value(W)
) (
    input  logic [W-1:0]         iData,
    input  logic [ROT_VALUE-1:0] iRotate,
    output logic [W-1:0]         oData
);

    logic [W-1:0] w_stage [0:ROT_VALUE];

    assign w_stage[0] = iData;

    for (genvar k = 0; k < ROT_VALUE; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = iRotate[k] ? ((w_stage[k] << SH) | (w_stage[k] >> (W - SH)))
                                         : w_stage[k];
    end

    assign oData = w_stage[ROT_VALUE];

endmodule

// File: rtl/rc5_encipher.sv
// RC5 encryption engine: pre-whitening plus R rounds, fetching expanded-key
// words from an external synchronous S memory one even/odd pair per round.
//
// state    | meaning
// IDLE     | waiting for iStart
// PRE_READ | memory latency for S[0]/S[1]
// PRE_ADD  | pre-whitening A+=S[0], B+=S[1]; fetch next pair
// RD       | memory latency for S[2i]/S[2i+1]
// MIX_A    | A = ((A^B)<<<B) + S[2i]
// MIX_B    | B = ((B^A)<<<A) + S[2i+1]; next round or finish
// DONE     | ciphertext valid, waiting for iStart
module rc5_encipher
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 12,
    localparam int ROT_VALUE = f_rot_value(W),
    localparam int T_LENGTH  = f_t_length(R)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic [T_LENGTH-1:0] oS_address1,
    output logic [T_LENGTH-1:0] oS_address2,
    input  logic [W-1:0]        iS_sub_i1,
    input  logic [W-1:0]        iS_sub_i2,
    output logic [W-1:0]        oA_cipher,
    output logic [W-1:0]        oB_cipher,
    output logic                oBusy,
    output logic                oDone
);

    localparam int CNT_W = $clog2(R + 1);

    rc5_state_e          r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [CNT_W-1:0]    r_cnt;
    logic [T_LENGTH-1:0] r_addr1;
    logic [T_LENGTH-1:0] r_addr2;
    logic                r_busy;
    logic                r_done;

    logic [W-1:0]        w_xor;
    logic [W-1:0]        w_rot_a;
    logic [W-1:0]        w_rot_b;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [T_LENGTH-1:0] w_addr_even;
    logic [T_LENGTH-1:0] w_addr_odd;

    assign w_xor       = r_a ^ r_b;
    assign w_cnt_next  = r_cnt + CNT_W'(1);
    assign w_addr_even = T_LENGTH'({w_cnt_next, 1'b0});
    assign w_addr_odd  = T_LENGTH'({w_cnt_next, 1'b1});

    // MIX_B rotates by the A value already written back in MIX_A
    rc5_rotl #(.W(W)) u_rotl_a (
        .iData   (w_xor),
        .iRotate (r_b[ROT_VALUE-1:0]),
        .oData   (w_rot_a)
    );

    rc5_rotl #(.W(W)) u_rotl_b (
        .iData   (w_xor),
        .iRotate (r_a[ROT_VALUE-1:0]),
        .oData   (w_rot_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= CNT_W'(1);
            r_addr1 <= T_LENGTH'(0);
            r_addr2 <= T_LENGTH'(1);
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (iStart) begin
                        r_a     <= iA;
                        r_b     <= iB;
                        r_addr1 <= T_LENGTH'(0);
                        r_addr2 <= T_LENGTH'(1);
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_PRE_READ;
                    end
                end
                ST_PRE_READ: r_state <= ST_PRE_ADD;
                ST_PRE_ADD: begin
                    r_a     <= r_a + iS_sub_i1;
                    r_b     <= r_b + iS_sub_i2;
                    r_addr1 <= T_LENGTH'(2);
                    r_addr2 <= T_LENGTH'(3);
                    r_cnt   <= CNT_W'(1);
                    r_state <= ST_RD;
                end
                ST_RD: r_state <= ST_MIX_A;
                ST_MIX_A: begin
                    r_a     <= w_rot_a + iS_sub_i1;
                    r_state <= ST_MIX_B;
                end
                ST_MIX_B: begin
                    r_b <= w_rot_b + iS_sub_i2;
                    if (r_cnt == CNT_W'(R)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= w_cnt_next;
                        r_addr1 <= w_addr_even;
                        r_addr2 <= w_addr_odd;
                        r_state <= ST_RD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oS_address1 = r_addr1;
    assign oS_address2 = r_addr2;
    assign oA_cipher   = r_a;
    assign oB_cipher   = r_b;
    assign oBusy       = r_busy;
    assign oDone       = r_done;

endmodule

// File: tb/tb_rc5_encipher.sv
// Scoreboard bench for rc5_encipher (W=32, R=12) with a synchronous S memory model.
module tb_rc5_encipher;
    import rc5_pkg::*;

    localparam int W   = 32;
    localparam int R   = 12;
    localparam int T   = 2 * (R + 1);
    localparam int LAT = 2 + 3 * R;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iStart = 1'b0;
    logic [31:0] iA = '0;
    logic [31:0] iB = '0;
    logic [4:0]  oS_address1;
    logic [4:0]  oS_address2;
    logic [31:0] iS_sub_i1 = '0;
    logic [31:0] iS_sub_i2 = '0;
    logic [31:0] oA_cipher;
    logic [31:0] oB_cipher;
    logic        oBusy;
    logic        oDone;

    logic [31:0] s_mem [0:T-1];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;

    rc5_encipher #(.W(W), .R(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .iStart      (iStart),
        .iA          (iA),
        .iB          (iB),
        .oS_address1 (oS_address1),
        .oS_address2 (oS_address2),
        .iS_sub_i1   (iS_sub_i1),
        .iS_sub_i2   (iS_sub_i2),
        .oA_cipher   (oA_cipher),
        .oB_cipher   (oB_cipher),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        iS_sub_i1 <= s_mem[oS_address1];
        iS_sub_i2 <= s_mem[oS_address2];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
        return (v << n) | (v >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic exp_t model(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        a = a_in + s_mem[0];
        b = b_in + s_mem[1];
        for (int i = 1; i <= R; i++) begin
            a = rotl32(a ^ b, b[4:0]) + s_mem[2*i];
            b = rotl32(b ^ a, a[4:0]) + s_mem[2*i+1];
        end
        e.a = a;
        e.b = b;
        return e;
    endfunction

    // Standard RC5 key schedule for a 16-byte all-zero key
    task automatic expand_zero_key();
        logic [31:0] lw [0:3];
        logic [63:0] p64;
        logic [63:0] q64;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] sum;
        int          i;
        int          j;
        for (int k = 0; k < 4; k++) lw[k] = '0;
        p64 = f_magic_p(32);
        q64 = f_magic_q(32);
        s_mem[0] = p64[31:0];
        for (int k = 1; k < T; k++) s_mem[k] = s_mem[k-1] + q64[31:0];
        x = '0; y = '0; i = 0; j = 0;
        for (int k = 0; k < 3 * T; k++) begin
            s_mem[i] = rotl32(s_mem[i] + x + y, 5'd3);
            x = s_mem[i];
            sum = x + y;
            lw[j] = rotl32(lw[j] + sum, sum[4:0]);
            y = lw[j];
            i = (i + 1) % T;
            j = (j + 1) % 4;
        end
    endtask

    task automatic fill_s(input bit random);
        for (int k = 0; k < T; k++) s_mem[k] = random ? $urandom : 32'h0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        iA = a;
        iB = b;
        iStart = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        iStart = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < LAT + 20; k++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errs++;
            $display("FAIL %s_timeout: pending=%0d required 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr1"}, 64'(oS_address1), 64'd0);
        check({tag, "_addr2"}, 64'(oS_address2), 64'd1);
        check({tag, "_a"},     64'(oA_cipher),   64'd0);
        check({tag, "_b"},     64'(oB_cipher),   64'd0);
        check({tag, "_busy"},  64'(oBusy),       64'd0);
        check({tag, "_done"},  64'(oDone),       64'd0);
    endtask

    // Monitor: address sequencing, latency and ciphertext on each done rise
    initial begin
        logic       pb;
        logic       pd;
        logic [4:0] pa;
        int         t0;
        exp_t       e;
        pb = 1'b0; pd = 1'b0; pa = '0; t0 = 0;
        forever begin
            @(negedge clk);
            if (oBusy && !pb) begin
                t0 = cyc;
                pa = '0;
                check("addr_first", {54'd0, oS_address2, oS_address1}, {54'd0, 5'd1, 5'd0});
            end else if (oBusy && oS_address1 != pa) begin
                check("addr_step", {54'd0, oS_address2, oS_address1},
                      {54'd0, pa + 5'd3, pa + 5'd2});
                pa = oS_address1;
            end
            if (oDone && !pd) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_done: got done=1 required no pending run");
                end else begin
                    e = sb.pop_front();
                    check("cipher_a", 64'(oA_cipher), 64'(e.a));
                    check("cipher_b", 64'(oB_cipher), 64'(e.b));
                    check("latency", 64'(cyc - t0), 64'(LAT));
                    check("busy_at_done", 64'(oBusy), 64'd0);
                    check("last_addr", 64'(pa), 64'(2 * R));
                end
            end
            pb = oBusy;
            pd = oDone;
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        exp_t        e2;

        fill_s(1'b0);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // all-zero key and plaintext
        issue(32'h0, 32'h0, '{a: 32'h0, b: 32'h0});
        wait_drain("zero");

        // published RC5-32/12/16 zero-key vector
        expand_zero_key();
        issue(32'h0, 32'h0, '{a: 32'hEEDBA521, b: 32'h6D8F4B15});
        wait_drain("vector");

        // rotate amounts 0 and 31 in the first round
        fill_s(1'b0);
        issue(32'h1, 32'h20, model(32'h1, 32'h20));
        wait_drain("rot0");
        issue(32'h1, 32'h1F, model(32'h1, 32'h1F));
        wait_drain("rot31");

        for (int n = 0; n < 4; n++) begin
            fill_s(1'b1);
            a = $urandom;
            b = $urandom;
            issue(a, b, model(a, b));
            wait_drain("random");
        end

        // start re-pulsed while busy is ignored
        a = 32'h0123_4567;
        b = 32'h89AB_CDEF;
        issue(a, b, model(a, b));
        repeat (9) @(negedge clk);
        iA = ~a;
        iB = ~b;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        wait_drain("repulse");

        // asynchronous reset mid-round, then a clean run
        issue(a, b, model(a, b));
        repeat (15) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_values("abort");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        issue(b, a, model(b, a));
        wait_drain("after_abort");

        // start held high across DONE: second run begins on the DONE cycle
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        e  = model(a, b);
        e2 = model(b, a);
        @(negedge clk);
        iA = a;
        iB = b;
        iStart = 1'b1;
        sb.push_back(e);
        sb.push_back(e2);
        @(negedge clk);
        iA = b;
        iB = a;
        for (int k = 0; k < LAT + 20; k++) begin
            @(posedge clk);
            if (sb.size() < 2) break;
        end
        @(negedge clk);
        iStart = 1'b0;
        wait_drain("b2b");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
